mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 255, bus-wait limit in cycles (used only when the timeout feature is built in).
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  reset, asynchronous and active-low.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept an access.
- req_op  in  3  access type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_pc  in  32  PC of the access, carried to the response.
- resp_valid  out  1  one-cycle completion strobe.
- resp_rdata  out  32  extended load data; 0 for stores and exceptions.
- resp_exc  out  1  access raised an exception.
- resp_exccode  out  5  4 AdEL, 5 AdES, 7 bus timeout.
- resp_pc  out  32  latched req_pc.
- bus_req  out  1  memory request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-aligned store data.
- bus_ack  in  1  memory completes the current request.
- bus_rdata  in  32  read word, valid with bus_ack.

Function
REQ-003 States SHALL be IDLE, BUS and RESP.
REQ-004 In IDLE, req_ready SHALL be 1; in BUS and RESP it SHALL be 0.
REQ-005 On req_valid and req_ready, the unit SHALL latch op, addr, wdata and pc.
REQ-006 A misaligned access (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0) SHALL go to RESP with exc=1, code 4 for loads and 5 for stores, and SHALL NOT assert bus_req.
REQ-007 An aligned access SHALL go to BUS. In BUS, bus_req SHALL be 1 and all bus_* outputs SHALL stay stable until bus_ack.
REQ-008 bus_be SHALL be: SB 0001<<addr[1:0]; SH 0011 if addr[1]=0, else 1100; SW and all loads 1111. bus_we SHALL be 1 only for stores.
REQ-009 bus_wdata SHALL be req_wdata[7:0] or [15:0] shifted into the enabled lanes with other lanes 0; for SW it SHALL be the full word.
REQ-010 On bus_ack in BUS, the unit SHALL capture bus_rdata and enter RESP. bus_ack SHALL be ignored outside BUS.
REQ-011 Load extraction SHALL be: LB sign-extends byte addr[1:0]; LBU zero-extends it; LH/LHU sign-/zero-extend halfword addr[1]; LW passes the word through.
REQ-012 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE. There is no response back-pressure.
REQ-013 Minimum latency with zero-wait ack SHALL be: accept at cycle 0, bus_req at cycle 1, resp_valid at cycle 2. The next acceptance SHALL be possible at cycle 3.

Reset
REQ-014 reset low SHALL immediately force IDLE, clear the latches, and drive every output to 0 except req_ready. req_ready SHALL go to 1 once reset is released.
REQ-015 A transaction interrupted by reset SHALL be dropped with no resp_valid. bus_req SHALL fall in the same cycle reset falls.

Configuration
REQ-016 With MAU_BUS_TIMEOUT_EN defined:
- A counter SHALL clear on BUS entry and increment on each BUS cycle without ack.
- When it reaches TIMEOUT_CYCLES, the unit SHALL drop bus_req and enter RESP with exc=1, code 7.
- An ack in that same cycle SHALL take precedence.
REQ-017 Without MAU_BUS_TIMEOUT_EN, no counter SHALL exist and BUS SHALL wait for bus_ack indefinitely.

Structure
REQ-018 Package mau_pkg SHALL hold the op encodings, the exception codes and the state enumeration.
REQ-019 Lane alignment and load extraction SHALL live in combinational sub-module mau_lane. The FSM, latches and timeout SHALL live in mem_access_unit.

Verification
REQ-020 SB addr 0x00001003 wdata 0x000000AB -> bus_addr 0x00001000, be 1000, wdata 0xAB000000, we 1, resp_rdata 0.
REQ-021 LB addr 0x00001001, bus_rdata 0x123480FF -> resp_rdata 0xFFFFFF80; LBU -> 0x00000080; LH addr 0x1002, rdata 0x80010000 -> 0xFFFF8001.
REQ-022 LW addr 0x00001002 -> resp_exc 1, code 4, bus_req never high. SH addr 0x00001001 -> code 5.
REQ-023 Zero-wait ack on back-to-back SW/LW -> resp_valid at cycles 2 and 5, and resp_pc matches each req_pc.
REQ-024 With MAU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=255 and ack withheld -> code 7 after 255 BUS cycles. Without the macro, ack at cycle 300 -> normal response.
REQ-025 reset low during BUS -> bus_req 0 immediately, no resp_valid, and req_ready 1 after release.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: op codes, exception codes, FSM states.
package mau_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  localparam logic [4:0] EXC_ADEL        = 5'd4;
  localparam logic [4:0] EXC_ADES        = 5'd5;
  localparam logic [4:0] EXC_BUS_TIMEOUT = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic misaligned(input op_e op, input logic [1:0] addr_lo);
    case (op)
      OP_LW, OP_SW:         return addr_lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return addr_lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte-lane steering: store data/byte enables onto the bus, load extraction from the bus word.
// Purely combinational, no latency, no flow control.
module mau_lane
  import mau_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = 8'(rdata >> {addr_lo, 3'b000});
  assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    load_data  = rdata;
    case (op)
      OP_SB: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {24'b0, wdata[7:0]} << {addr_lo, 3'b000};
      end
      OP_SH: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = addr_lo[1] ? {wdata[15:0], 16'b0} : {16'b0, wdata[15:0]};
      end
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'b0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'b0, rd_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit, one access in flight: accept -> bus (until ack) -> one-cycle response, 2 cycles minimum, no response back-pressure.
// Define MAU_BUS_TIMEOUT_EN to abort a bus wait after TIMEOUT_CYCLES with exception code 7.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exccode,
  output logic [31:0] resp_pc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_e      state, state_nxt;
  op_e         req_op_e, op_q;
  logic [31:0] addr_q, wdata_q, pc_q, rdata_q;
  logic        exc_q;
  logic [4:0]  code_q;
  logic        req_mis, tmo_hit;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  assign req_op_e = op_e'(req_op);
  assign req_mis  = misaligned(req_op_e, req_addr[1:0]);

`ifdef MAU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 tmo_cnt <= '0;
    else if (state != ST_BUS)   tmo_cnt <= '0;
    else if (!bus_ack)          tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Fires in the TIMEOUT_CYCLES-th ack-less bus cycle; an ack that cycle still wins.
  assign tmo_hit = (state == ST_BUS) && !bus_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    bus_req    = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = reset;
        if (req_valid) state_nxt = req_mis ? ST_RESP : ST_BUS;
      end
      ST_BUS: begin
        bus_req = 1'b1;
        if (bus_ack || tmo_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
      code_q  <= '0;
    end else if (state == ST_IDLE && req_valid) begin
      op_q    <= req_op_e;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      pc_q    <= req_pc;
      rdata_q <= '0;
      exc_q   <= req_mis;
      code_q  <= req_mis ? (is_store(req_op_e) ? EXC_ADES : EXC_ADEL) : 5'd0;
    end else if (state == ST_BUS) begin
      if (bus_ack) begin
        rdata_q <= bus_rdata;
      end else if (tmo_hit) begin
        exc_q  <= 1'b1;
        code_q <= EXC_BUS_TIMEOUT;
      end
    end
  end

  mau_lane u_lane (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (rdata_q),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .load_data  (lane_load)
  );

  // Bus fields are held at zero outside BUS so the memory side sees a clean idle bus.
  assign bus_we       = bus_req && is_store(op_q);
  assign bus_addr     = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_be       = bus_req ? lane_be : 4'd0;
  assign bus_wdata    = bus_we ? lane_wdata : 32'd0;

  assign resp_exc     = resp_valid && exc_q;
  assign resp_exccode = resp_valid ? code_q : 5'd0;
  assign resp_rdata   = (resp_valid && !exc_q && !is_store(op_q)) ? lane_load : 32'd0;
  assign resp_pc      = pc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand sequences, random vs reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
  logic        resp_valid, resp_exc;
  logic [31:0] resp_rdata, resp_pc;
  logic [4:0]  resp_exccode;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .resp_exccode(resp_exccode), .resp_pc(resp_pc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr, wdata, rdata;
    logic        exc;
    logic [4:0]  code;
    logic        we;
    logic [3:0]  be;
    logic [31:0] bwdata, rres;
  } vec_t;

  typedef struct {
    logic        bus_seen, stable, resp, we, exc;
    logic [31:0] baddr, bwdata, rdata, pc;
    logic [3:0]  be;
    logic [4:0]  code;
    int          acc_cyc, resp_cyc, lat, bus_cycles;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: access size, lane offset and sign rules computed arithmetically.
  task automatic model(input logic [2:0] op, input logic [31:0] addr, wdata, rdata,
                       output logic mis, output logic [4:0] code, output logic we,
                       output logic [3:0] be, output logic [31:0] bw, output logic [31:0] rr);
    int size, off;
    logic st, sgn;
    logic [31:0] mask, v;
    size = (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1;
    off  = int'(addr[1:0]);
    st   = (op >= 3'd5);
    sgn  = (op == 3'd1 || op == 3'd3);
    mis  = (off % size) != 0;
    code = mis ? (st ? 5'd5 : 5'd4) : 5'd0;
    we   = st;
    be   = st ? 4'(((1 << size) - 1) << off) : 4'hF;
    mask = (size == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * size)) - 1);
    bw   = st ? ((wdata & mask) << (8 * off)) : 32'd0;
    v    = (rdata >> (8 * off)) & mask;
    if (sgn && v[8*size-1]) v = v | ~mask;
    rr   = (st || mis) ? 32'd0 : v;
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, wdata, pc, rdata,
                         input int ack_wait, output res_t r);
    r = '{default: 0};
    r.stable = 1'b1;
    @(negedge clk);
    r.acc_cyc = cyc;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
    for (int n = 0; n < 700 && !r.resp; n++) begin
      @(negedge clk);
      if (bus_req) begin
        if (!r.bus_seen) begin
          r.bus_seen = 1'b1; r.baddr = bus_addr; r.be = bus_be; r.we = bus_we; r.bwdata = bus_wdata;
        end else if (bus_addr !== r.baddr || bus_be !== r.be || bus_we !== r.we || bus_wdata !== r.bwdata) begin
          r.stable = 1'b0;
        end
        r.bus_cycles++;
      end
      if (resp_valid) begin
        r.resp = 1'b1; r.rdata = resp_rdata; r.exc = resp_exc; r.code = resp_exccode; r.pc = resp_pc;
        r.resp_cyc = cyc; r.lat = cyc - r.acc_cyc;
      end
      if (bus_req && r.bus_cycles > ack_wait) begin
        bus_ack = 1'b1; bus_rdata = rdata;
      end else begin
        bus_ack = 1'b0; bus_rdata = $urandom;
      end
    end
    bus_ack = 1'b0;
    chk("resp_seen", 32'(r.resp), 32'd1);
  endtask

  vec_t vecs[12];
  res_t r, r2;

  initial begin
    vecs[0]  = '{3'd7, 32'h0000_1003, 32'h0000_00AB, 32'h5555_5555, 0, 0, 1, 4'b1000, 32'hAB00_0000, 32'h0};
    vecs[1]  = '{3'd3, 32'h0000_1001, 32'h0, 32'h1234_80FF, 0, 0, 0, 4'hF, 32'h0, 32'hFFFF_FF80};
    vecs[2]  = '{3'd4, 32'h0000_1001, 32'h0, 32'h1234_80FF, 0, 0, 0, 4'hF, 32'h0, 32'h0000_0080};
    vecs[3]  = '{3'd1, 32'h0000_1002, 32'h0, 32'h8001_0000, 0, 0, 0, 4'hF, 32'h0, 32'hFFFF_8001};
    vecs[4]  = '{3'd2, 32'h0000_1002, 32'h0, 32'h8001_0000, 0, 0, 0, 4'hF, 32'h0, 32'h0000_8001};
    vecs[5]  = '{3'd0, 32'h0000_1002, 32'h0, 32'h1111_1111, 1, 4, 0, 4'h0, 32'h0, 32'h0};
    vecs[6]  = '{3'd6, 32'h0000_1001, 32'hFFFF, 32'h0, 1, 5, 0, 4'h0, 32'h0, 32'h0};
    vecs[7]  = '{3'd6, 32'h0000_1002, 32'h1234_ABCD, 32'h0, 0, 0, 1, 4'b1100, 32'hABCD_0000, 32'h0};
    vecs[8]  = '{3'd0, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 4'hF, 32'h0, 32'hDEAD_BEEF};
    vecs[9]  = '{3'd5, 32'h0000_1004, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{3'd3, 32'h0000_3000, 32'h0, 32'hFFFF_FF7F, 0, 0, 0, 4'hF, 32'h0, 32'h0000_007F};
    vecs[11] = '{3'd5, 32'h0000_1001, 32'h1, 32'h0, 1, 5, 0, 4'h0, 32'h0, 32'h0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_outputs", {bus_addr ^ bus_wdata ^ resp_rdata ^ resp_pc, bus_be, resp_exccode, resp_exc, bus_we}, 0);
    reset = 1'b1;
    #1;
    chk("rst_release_ready", 32'(req_ready), 1);

    // bus_ack outside BUS is ignored.
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("idle_ack_resp", 32'(resp_valid), 0);
    chk("idle_ack_ready", 32'(req_ready), 1);
    bus_ack = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, 32'h400 + 32'(i), vecs[i].rdata, i % 3, r);
      chk($sformatf("vec%0d_exc", i), 32'(r.exc), 32'(vecs[i].exc));
      chk($sformatf("vec%0d_code", i), 32'(r.code), 32'(vecs[i].code));
      chk($sformatf("vec%0d_rdata", i), r.rdata, vecs[i].rres);
      chk($sformatf("vec%0d_pc", i), r.pc, 32'h400 + 32'(i));
      chk($sformatf("vec%0d_bus_seen", i), 32'(r.bus_seen), 32'(!vecs[i].exc));
      if (!vecs[i].exc) begin
        chk($sformatf("vec%0d_addr", i), r.baddr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("vec%0d_be", i), 32'(r.be), 32'(vecs[i].be));
        chk($sformatf("vec%0d_we", i), 32'(r.we), 32'(vecs[i].we));
        chk($sformatf("vec%0d_wdata", i), r.bwdata, vecs[i].bwdata);
        chk($sformatf("vec%0d_lat", i), r.lat, (i % 3) + 2);
      end else begin
        chk($sformatf("vec%0d_lat", i), r.lat, 1);
      end
    end

    // Back-to-back zero-wait SW then LW.
    run_txn(3'd5, 32'h0000_0100, 32'hA5A5_0001, 32'h0000_1111, 32'h0, 0, r);
    run_txn(3'd0, 32'h0000_0200, 32'h0, 32'h0000_2222, 32'h7777_8888, 0, r2);
    chk("b2b_resp1_cycle", r.resp_cyc - r.acc_cyc, 2);
    chk("b2b_resp2_cycle", r2.resp_cyc - r.acc_cyc, 5);
    chk("b2b_pc1", r.pc, 32'h0000_1111);
    chk("b2b_pc2", r2.pc, 32'h0000_2222);
    chk("b2b_rdata2", r2.rdata, 32'h7777_8888);

    // Long bus wait.
`ifdef MAU_BUS_TIMEOUT_EN
    run_txn(3'd0, 32'h0000_0300, 32'h0, 32'h0000_3333, 32'h9999_9999, 100000, r);
    chk("tmo_exc", 32'(r.exc), 1);
    chk("tmo_code", 32'(r.code), 7);
    chk("tmo_bus_cycles", r.bus_cycles, 255);
    chk("tmo_rdata", r.rdata, 0);
`else
    run_txn(3'd0, 32'h0000_0300, 32'h0, 32'h0000_3333, 32'h9999_9999, 299, r);
    chk("wait_exc", 32'(r.exc), 0);
    chk("wait_lat", r.lat, 301);
    chk("wait_rdata", r.rdata, 32'h9999_9999);
    chk("wait_stable", 32'(r.stable), 1);
`endif

    // Reset in the middle of a bus wait.
    begin
      int resp_seen;
      resp_seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h0000_0400; req_pc = 32'h0000_4444;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rstbus_req_before", 32'(bus_req), 1);
      #2 reset = 1'b0;
      #1;
      chk("rstbus_req_after", 32'(bus_req), 0);
      chk("rstbus_outputs", {bus_addr ^ resp_pc, bus_be, resp_exccode, resp_exc, resp_valid}, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rstbus_ready", 32'(req_ready), 1);
      repeat (4) begin
        @(negedge clk);
        if (resp_valid) resp_seen++;
      end
      chk("rstbus_no_resp", resp_seen, 0);
    end

    // Random accesses against the reference model.
    for (int k = 0; k < 60; k++) begin
      logic [2:0]  op;
      logic [31:0] addr, wdata, rdata, pc, bw, rr;
      logic        mis, we;
      logic [4:0]  code;
      logic [3:0]  be;
      int          aw;
      op = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wdata = $urandom; rdata = $urandom; pc = $urandom;
      aw = $urandom_range(0, 3);
      model(op, addr, wdata, rdata, mis, code, we, be, bw, rr);
      run_txn(op, addr, wdata, pc, rdata, aw, r);
      chk("rnd_exc", 32'(r.exc), 32'(mis));
      chk("rnd_code", 32'(r.code), 32'(code));
      chk("rnd_rdata", r.rdata, rr);
      chk("rnd_pc", r.pc, pc);
      chk("rnd_bus_seen", 32'(r.bus_seen), 32'(!mis));
      if (!mis) begin
        chk("rnd_addr", r.baddr, {addr[31:2], 2'b00});
        chk("rnd_be", 32'(r.be), 32'(be));
        chk("rnd_we", 32'(r.we), 32'(we));
        chk("rnd_wdata", r.bwdata, bw);
        chk("rnd_stable", 32'(r.stable), 1);
        chk("rnd_lat", r.lat, aw + 2);
      end else begin
        chk("rnd_lat", r.lat, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
